// File: rtl/alu_hs.sv
// Registered ALU with valid/ready handshake and persistent N/V/C/Z flag register.
// Latency 1 cycle from accept to out_valid; 1 op/cycle while the consumer keeps out_ready high.
// Backpressure: in_ready = !out_valid || out_ready; a held result freezes res/flags/out_valid.
module alu_hs #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flags
);

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_ADC = 3'd2,
      OP_SBC = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_CMP = 3'd7
   } op_e;

   // Flag bit positions inside the {N,V,C,Z} vector.
   localparam int FLAG_N = 3;
   localparam int FLAG_V = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_Z = 0;

   op_e              op_sel;
   logic             accept;
   logic             is_arith;
   logic             is_sub;
   logic             carry_in;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] alu_res;
   logic             ovf;
   logic [3:0]       flags_new;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [3:0]       flags_q, flags_d;

   assign op_sel   = op_e'(op);
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Decode the opcode into adder controls and the bitwise result.
   // Chained ops read the committed C flag straight from the flag register, which
   // already holds the previous accept's carry on the next edge.
   always_comb begin
      is_arith  = 1'b0;
      is_sub    = 1'b0;
      carry_in  = 1'b0;
      logic_res = '0;
      case (op_sel)
         OP_ADD: begin
            is_arith = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            is_arith = 1'b1;
            is_sub   = 1'b1;
            carry_in = 1'b1;
         end
         OP_ADC: begin
            is_arith = 1'b1;
            carry_in = flags_q[FLAG_C];
         end
         OP_SBC: begin
            is_arith = 1'b1;
            is_sub   = 1'b1;
            carry_in = flags_q[FLAG_C];
         end
         OP_AND: logic_res = opA & opB;
         OP_OR:  logic_res = opA | opB;
         OP_XOR: logic_res = opA ^ opB;
         default: logic_res = '0;
      endcase
   end

   // WIDTH+1-bit adder; subtract forms add the inverted B operand.
   always_comb begin
      b_eff = is_sub ? ~opB : opB;
      sum   = {1'b0, opA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_in};
   end

   // Select the result and form the candidate flag vector; logic ops keep C and V.
   always_comb begin
      alu_res   = is_arith ? sum[WIDTH-1:0] : logic_res;
      ovf       = (opA[WIDTH-1] == b_eff[WIDTH-1]) && (alu_res[WIDTH-1] != opA[WIDTH-1]);
      flags_new = flags_q;
      flags_new[FLAG_N] = alu_res[WIDTH-1];
      flags_new[FLAG_Z] = (alu_res == '0);
      if (is_arith) begin
         flags_new[FLAG_V] = ovf;
         flags_new[FLAG_C] = sum[WIDTH];
      end
   end

   // Output register next state: accept loads (CMP leaves res alone), consume-only empties.
   always_comb begin
      out_valid_d = out_valid_q;
      res_d       = res_q;
      flags_d     = flags_q;
      if (accept) begin
         out_valid_d = 1'b1;
         flags_d     = flags_new;
         if (op_sel != OP_CMP) begin
            res_d = alu_res;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset drops any pending result immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= 4'b0000;
      end else begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign res       = res_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_hs.sv
// Bench for alu_hs at WIDTH=8 and WIDTH=16 sharing one stimulus driver.
// Directed checks against literal values plus a queue scoreboard fed by a reference model.
// sel chooses which instance receives in_valid; out_ready is shared.
module tb_alu_hs;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_ADC = 3'd2, OP_SBC = 3'd3,
                          OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_CMP = 3'd7;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sel = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  op = 3'd0;
   logic [15:0] opA = 16'h0;
   logic [15:0] opB = 16'h0;

   logic        in_valid8, in_ready8, out_valid8;
   logic [7:0]  res8;
   logic [3:0]  flags8;
   logic        in_valid16, in_ready16, out_valid16;
   logic [15:0] res16;
   logic [3:0]  flags16;

   logic        cur_in_ready, cur_out_valid;
   logic [15:0] cur_res;
   logic [3:0]  cur_flags;

   int checks = 0;
   int failures = 0;

   logic [19:0] q8[$];
   logic [19:0] q16[$];
   logic [3:0]  mf8 = 4'h0, mf16 = 4'h0;
   logic [15:0] mr8 = 16'h0, mr16 = 16'h0;

   assign in_valid8     = in_valid & ~sel;
   assign in_valid16    = in_valid & sel;
   assign cur_in_ready  = sel ? in_ready16 : in_ready8;
   assign cur_out_valid = sel ? out_valid16 : out_valid8;
   assign cur_res       = sel ? res16 : {8'h00, res8};
   assign cur_flags     = sel ? flags16 : flags8;

   alu_hs #(.WIDTH(8)) u_alu8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op),
      .opA(opA[7:0]), .opB(opB[7:0]), .out_valid(out_valid8), .out_ready(out_ready),
      .res(res8), .flags(flags8)
   );

   alu_hs #(.WIDTH(16)) u_alu16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op),
      .opA(opA), .opB(opB), .out_valid(out_valid16), .out_ready(out_ready),
      .res(res16), .flags(flags16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: returns {N,V,C,Z, res} for a w-bit ALU.
   function automatic logic [19:0] model(input logic [2:0] o, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] fl,
                                         input logic [15:0] pr, input int w);
      logic [31:0] mask, am, bm, bb, s, r;
      logic n, v, c, z, arith;
      mask  = (32'd1 << w) - 32'd1;
      am    = {16'h0, a} & mask;
      bm    = {16'h0, b} & mask;
      bb    = bm;
      arith = 1'b1;
      v     = fl[2];
      c     = fl[1];
      case (o)
         OP_ADD: s = am + bm;
         OP_SUB, OP_CMP: begin bb = ~bm & mask; s = am + bb + 32'd1; end
         OP_ADC: s = am + bm + {31'd0, fl[1]};
         OP_SBC: begin bb = ~bm & mask; s = am + bb + {31'd0, fl[1]}; end
         OP_AND: begin s = am & bm; arith = 1'b0; end
         OP_OR:  begin s = am | bm; arith = 1'b0; end
         default: begin s = am ^ bm; arith = 1'b0; end
      endcase
      r = s & mask;
      n = r[w-1];
      z = (r == 32'd0);
      if (arith) begin
         c = s[w];
         v = (am[w-1] == bb[w-1]) && (r[w-1] != am[w-1]);
      end
      return {n, v, c, z, (o == OP_CMP) ? pr : r[15:0]};
   endfunction

   // Scoreboard for the 8-bit instance: pop on transfer, push on accept.
   always @(negedge clk) begin : mon8
      logic [19:0] e;
      if (rst_n) begin
         if (out_valid8 && out_ready) begin
            if (q8.size() == 0) chk("sb8_underflow", q8.size(), 1);
            else begin
               e = q8.pop_front();
               chk("sb8_res", {24'h0, res8}, {16'h0, e[15:0]});
               chk("sb8_flags", {28'h0, flags8}, {28'h0, e[19:16]});
            end
         end
         if (in_valid8 && in_ready8) begin
            e = model(op, opA, opB, mf8, mr8, 8);
            mf8 = e[19:16];
            mr8 = e[15:0];
            q8.push_back(e);
         end
      end
   end

   // Scoreboard for the 16-bit instance.
   always @(negedge clk) begin : mon16
      logic [19:0] e;
      if (rst_n) begin
         if (out_valid16 && out_ready) begin
            if (q16.size() == 0) chk("sb16_underflow", q16.size(), 1);
            else begin
               e = q16.pop_front();
               chk("sb16_res", {16'h0, res16}, {16'h0, e[15:0]});
               chk("sb16_flags", {28'h0, flags16}, {28'h0, e[19:16]});
            end
         end
         if (in_valid16 && in_ready16) begin
            e = model(op, opA, opB, mf16, mr16, 16);
            mf16 = e[19:16];
            mr16 = e[15:0];
            q16.push_back(e);
         end
      end
   end

   // Present one op and return #1 after the edge that accepted it.
   task automatic issue(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1; op = o; opA = a; opB = b;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (cur_in_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", {31'h0, cur_in_ready}, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] r, input logic [3:0] f);
      chk({tag, "_vld"}, {31'h0, cur_out_valid}, 1);
      chk({tag, "_res"}, {16'h0, cur_res}, {16'h0, r});
      chk({tag, "_flg"}, {28'h0, cur_flags}, {28'h0, f});
   endtask

   task automatic rand_phase(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         op        = 3'($urandom_range(0, 7));
         opA       = 16'($urandom);
         opB       = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("drain_q8", q8.size(), 0);
      chk("drain_q16", q16.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin : stim
      #1;
      chk("rst_vld8", {31'h0, out_valid8}, 0);
      chk("rst_res8", {24'h0, res8}, 0);
      chk("rst_flg8", {28'h0, flags8}, 0);
      chk("rst_rdy8", {31'h0, in_ready8}, 1);
      chk("rst_vld16", {31'h0, out_valid16}, 0);
      chk("rst_res16", {16'h0, res16}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 8-bit arithmetic, flags and carry chaining
      issue(OP_ADD, 16'h7F, 16'h01); expect_out("add8", 16'h80, 4'b1100);
      issue(OP_SUB, 16'h05, 16'h05); expect_out("sub8", 16'h00, 4'b0011);
      issue(OP_SBC, 16'h00, 16'h01); expect_out("sbc8", 16'hFF, 4'b1000);
      issue(OP_ADD, 16'hFF, 16'h01); expect_out("lo8", 16'h00, 4'b0011);
      issue(OP_ADC, 16'h00, 16'h00); expect_out("hi8", 16'h01, 4'b0000);

      // CMP keeps res; logic ops keep C and V
      issue(OP_OR,  16'h3C, 16'h00); expect_out("or8", 16'h3C, 4'b0000);
      issue(OP_CMP, 16'h10, 16'h20); expect_out("cmp8", 16'h3C, 4'b1000);
      issue(OP_AND, 16'hF0, 16'h0F); expect_out("and8", 16'h00, 4'b0001);
      issue(OP_ADD, 16'hFF, 16'h01); expect_out("setc8", 16'h00, 4'b0011);
      issue(OP_XOR, 16'h80, 16'h00); expect_out("xorc8", 16'h80, 4'b1010);
      issue(OP_ADD, 16'h7F, 16'h01); expect_out("setv8", 16'h80, 4'b1100);
      issue(OP_AND, 16'hFF, 16'hFF); expect_out("andv8", 16'hFF, 4'b1100);

      // Backpressure: hold result for 5 cycles with a pending op
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(OP_ADD, 16'h11, 16'h22); expect_out("stall0", 16'h33, 4'b0000);
      in_valid = 1'b1; op = OP_SUB; opA = 16'h50; opB = 16'h10;
      repeat (5) begin
         @(negedge clk);
         chk("stall_rdy", {31'h0, cur_in_ready}, 0);
         chk("stall_vld", {31'h0, cur_out_valid}, 1);
         chk("stall_res", {16'h0, cur_res}, 32'h33);
         chk("stall_flg", {28'h0, cur_flags}, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      expect_out("rel_sub", 16'h40, 4'b0010);
      issue(OP_ADD, 16'h01, 16'h01); expect_out("rel_add", 16'h02, 4'b0000);

      rand_phase(60);

      // Asynchronous reset while a result is held
      out_ready = 1'b0;
      issue(OP_ADD, 16'h0F, 16'hF1); expect_out("pre_rst", 16'h00, 4'b0011);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", {31'h0, out_valid8}, 0);
      chk("arst_res", {24'h0, res8}, 0);
      chk("arst_flg", {28'h0, flags8}, 0);
      chk("arst_rdy", {31'h0, in_ready8}, 1);
      q8.delete(); mf8 = 4'h0; mr8 = 16'h0;
      q16.delete(); mf16 = 4'h0; mr16 = 16'h0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_vld", {31'h0, out_valid8}, 0);

      // 16-bit rerun
      sel = 1'b1;
      issue(OP_ADD, 16'h7FFF, 16'h0001); expect_out("add16", 16'h8000, 4'b1100);
      issue(OP_SUB, 16'h0005, 16'h0005); expect_out("sub16", 16'h0000, 4'b0011);
      issue(OP_SBC, 16'h0000, 16'h0001); expect_out("sbc16", 16'hFFFF, 4'b1000);
      issue(OP_ADD, 16'hFFFF, 16'h0001); expect_out("lo16", 16'h0000, 4'b0011);
      issue(OP_ADC, 16'h0000, 16'h0000); expect_out("hi16", 16'h0001, 4'b0000);
      issue(OP_CMP, 16'h1000, 16'h2000); expect_out("cmp16", 16'h0001, 4'b1000);

      rand_phase(60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
